// File: rtl/sysctl_pkg.sv
// Shared types and helpers for the system-control reset / clock-enable block.
package sysctl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STRETCH = 2'd2
    } state_t;

    localparam int CAUSE_RESET = 0;

    // Divider wide enough for the slowest enable, which divides by 2^(base+num-1).
    function automatic int div_width(input int base_log2, input int ce_num);
        return base_log2 + ce_num - 1;
    endfunction

endpackage

// File: rtl/sysctl_ce_div.sv
// Free-running divider producing phase-aligned one-cycle clock enables.
module sysctl_ce_div
    import sysctl_pkg::*;
#(
    parameter int CE_NUM       = 2,
    parameter int CE_BASE_LOG2 = 2
) (
    input  logic              clk_sys,
    input  logic              clear,
    output logic [CE_NUM-1:0] ce_o
);

    localparam int DW = div_width(CE_BASE_LOG2, CE_NUM);

    logic [DW-1:0]     div_q;
    logic [CE_NUM-1:0] ce_d;

    // Enable n fires when the low CE_BASE_LOG2+n divider bits are all zero.
    always_comb begin
        ce_d = '0;
        for (int n = 0; n < CE_NUM; n++) begin
            ce_d[n] = !clear && ((div_q & DW'((1 << (CE_BASE_LOG2 + n)) - 1)) == '0);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (clear) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
        ce_o <= ce_d;
    end

endmodule

// File: rtl/sysctl_reset_ce.sv
// Core reset merger/stretcher with cause reporting plus clock-enable bank.
// Optional reset on configuration change: define SYSCTL_CFG_RST_EN.
module sysctl_reset_ce
    import sysctl_pkg::*;
#(
    parameter int CE_NUM       = 2,
    parameter int CE_BASE_LOG2 = 2,
    parameter int SRC_NUM      = 4,
    parameter int CFG_W        = 5,
    parameter int STRETCH      = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [SRC_NUM-1:0] rst_src_i,
    input  logic [CFG_W-1:0]   cfg_i,
    output logic               sys_reset_o,
    output logic               rst_done_o,
    output logic [SRC_NUM+1:0] rst_cause_o,
    output logic [CE_NUM-1:0]  ce_o
);

    localparam int             CW             = SRC_NUM + 2;
    localparam logic [15:0]    STRETCH_M1     = 16'(STRETCH - 1);
    localparam logic [CW-1:0]  CAUSE_ON_RESET = CW'(1) << CAUSE_RESET;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            cfg_chg;
    logic [CW-1:0]   req_bits;
    logic            req;
    logic            sys_reset_q;
    logic            done_q;
    logic [CW-1:0]   cause_q;
    logic            div_clear;

`ifdef SYSCTL_CFG_RST_EN
    logic [CFG_W-1:0] cfg_q;

    always_ff @(posedge clk_sys) begin
        cfg_q <= cfg_i;
    end

    assign cfg_chg = (cfg_i != cfg_q);
`else
    logic unused_cfg;

    assign unused_cfg = ^cfg_i;
    assign cfg_chg    = 1'b0;
`endif

    assign req_bits = {cfg_chg, rst_src_i, reset};
    assign req      = |req_bits;

    // The HOLD cycle counts as the first stretch cycle so reset lasts exactly STRETCH cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (req) begin
                    state_d = ST_HOLD;
                    cnt_d   = STRETCH_M1;
                end
            end
            ST_HOLD, ST_STRETCH: begin
                if (req) begin
                    state_d = ST_HOLD;
                    cnt_d   = STRETCH_M1;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STRETCH;
                    cnt_d   = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = STRETCH_M1;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            cnt_q       <= STRETCH_M1;
            sys_reset_q <= 1'b1;
            done_q      <= 1'b0;
            cause_q     <= CAUSE_ON_RESET;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_reset_q <= (state_d != ST_RUN);
            done_q      <= sys_reset_q && (state_d == ST_RUN);
            // A fresh episode forgets the previous cause; an ongoing one accumulates.
            if (state_q == ST_RUN) begin
                if (req) begin
                    cause_q <= req_bits;
                end
            end else begin
                cause_q <= cause_q | req_bits;
            end
        end
    end

    assign div_clear = sys_reset_q | reset;

    sysctl_ce_div #(
        .CE_NUM      (CE_NUM),
        .CE_BASE_LOG2(CE_BASE_LOG2)
    ) u_ce_div (
        .clk_sys(clk_sys),
        .clear  (div_clear),
        .ce_o   (ce_o)
    );

    assign sys_reset_o = sys_reset_q;
    assign rst_done_o  = done_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_sysctl_reset_ce.sv
// Self-checking bench for sysctl_reset_ce: window-based reference model plus directed literals.
module tb_sysctl_reset_ce;

    localparam int CE_NUM       = 2;
    localparam int CE_BASE_LOG2 = 2;
    localparam int SRC_NUM      = 4;
    localparam int CFG_W        = 5;
    localparam int STRETCH      = 16;
`ifdef SYSCTL_CFG_RST_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    logic               clk_sys   = 1'b0;
    logic               reset     = 1'b1;
    logic [SRC_NUM-1:0] rst_src_i = '0;
    logic [CFG_W-1:0]   cfg_i     = '0;
    logic               sys_reset_o;
    logic               rst_done_o;
    logic [SRC_NUM+1:0] rst_cause_o;
    logic [CE_NUM-1:0]  ce_o;

    sysctl_reset_ce #(
        .CE_NUM      (CE_NUM),
        .CE_BASE_LOG2(CE_BASE_LOG2),
        .SRC_NUM     (SRC_NUM),
        .CFG_W       (CFG_W),
        .STRETCH     (STRETCH)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .rst_src_i  (rst_src_i),
        .cfg_i      (cfg_i),
        .sys_reset_o(sys_reset_o),
        .rst_done_o (rst_done_o),
        .rst_cause_o(rst_cause_o),
        .ce_o       (ce_o)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = -1;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: reset is high while a request lies within the last STRETCH cycles;
    // enables are a function of the distance from the cycle reset was released.
    int                 m_last_req  = -1000;
    int                 m_run_start = 0;
    bit                 m_valid     = 1'b0;
    logic               m_rst       = 1'b1;
    logic               m_prev_rst  = 1'b1;
    logic               m_done      = 1'b0;
    logic [SRC_NUM+1:0] m_cause     = 6'd1;
    logic [CE_NUM-1:0]  m_ce        = '0;
    logic [CFG_W-1:0]   m_prev_cfg  = '0;
    logic               n_rst;
    logic [SRC_NUM+1:0] n_bits;
    logic [CE_NUM-1:0]  n_ce;

    always @(negedge clk_sys) begin
        if (m_valid) begin
            checkOutput("model_sys_reset", 32'(sys_reset_o), 32'(m_rst));
            checkOutput("model_rst_done", 32'(rst_done_o), 32'(m_done));
            checkOutput("model_rst_cause", 32'(rst_cause_o), 32'(m_cause));
            checkOutput("model_ce", 32'(ce_o), 32'(m_ce));
        end
        n_bits = {CFG_EN && (cfg_i != m_prev_cfg), rst_src_i, reset};
        if (|n_bits) m_last_req = cyc;
        n_rst = (cyc - m_last_req) < STRETCH;
        if (!m_rst && m_prev_rst) m_run_start = cyc;
        for (int n = 0; n < CE_NUM; n++) begin
            n_ce[n] = m_valid && !m_rst && !reset &&
                      (((cyc - m_run_start) % (1 << (CE_BASE_LOG2 + n))) == 0);
        end
        m_done = m_rst && !n_rst;
        if (reset) m_cause = 6'd1;
        else if (!m_rst && (|n_bits)) m_cause = n_bits;
        else if (m_rst) m_cause = m_cause | n_bits;
        m_prev_rst = m_rst;
        m_rst      = n_rst;
        m_ce       = n_ce;
        m_prev_cfg = cfg_i;
        if (reset) m_valid = 1'b1;
    end

    task automatic applyStimulus(input int k);
        while (cyc < k) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        applyStimulus(0);
        checkOutput("rst_sys_c0", 32'(sys_reset_o), 32'd1);
        checkOutput("rst_cause_c0", 32'(rst_cause_o), 32'h01);
        checkOutput("rst_ce_c0", 32'(ce_o), 32'd0);
        applyStimulus(3);  reset = 1'b0;
        applyStimulus(18); checkOutput("rel_sys_c18", 32'(sys_reset_o), 32'd1);
        checkOutput("rel_ce_c18", 32'(ce_o), 32'd0);
        applyStimulus(19); checkOutput("rel_sys_c19", 32'(sys_reset_o), 32'd0);
        checkOutput("rel_done_c19", 32'(rst_done_o), 32'd1);
        checkOutput("rel_cause_c19", 32'(rst_cause_o), 32'h01);
        applyStimulus(20); checkOutput("rel_done_c20", 32'(rst_done_o), 32'd0);
        checkOutput("ce_r1", 32'(ce_o), 32'h3);
        applyStimulus(24); checkOutput("ce_r5", 32'(ce_o), 32'h1);
        applyStimulus(28); checkOutput("ce_r9", 32'(ce_o), 32'h3);

        applyStimulus(40); rst_src_i = 4'b0100;
        applyStimulus(41); rst_src_i = 4'b0000;
        checkOutput("src2_sys", 32'(sys_reset_o), 32'd1);
        checkOutput("src2_cause", 32'(rst_cause_o), 32'h08);
        applyStimulus(56); checkOutput("src2_sys_end", 32'(sys_reset_o), 32'd1);
        applyStimulus(57); checkOutput("src2_sys_off", 32'(sys_reset_o), 32'd0);
        checkOutput("src2_done", 32'(rst_done_o), 32'd1);

        applyStimulus(70);  rst_src_i = 4'b0001;
        applyStimulus(71);  checkOutput("held_cause", 32'(rst_cause_o), 32'h02);
        applyStimulus(110); rst_src_i = 4'b0000;
        applyStimulus(125); checkOutput("held_sys_end", 32'(sys_reset_o), 32'd1);
        applyStimulus(126); checkOutput("held_done", 32'(rst_done_o), 32'd1);

        applyStimulus(140); cfg_i = 5'h02;
        applyStimulus(141); checkOutput("cfg_sys", 32'(sys_reset_o), 32'(CFG_EN));
        checkOutput("cfg_cause", 32'(rst_cause_o), CFG_EN ? 32'h20 : 32'h02);

        applyStimulus(170); rst_src_i = 4'b0010;
        applyStimulus(171); rst_src_i = 4'b0000;
        checkOutput("str_cause0", 32'(rst_cause_o), 32'h04);
        applyStimulus(181); rst_src_i = 4'b0001; cfg_i = 5'h05;
        applyStimulus(182); rst_src_i = 4'b0000;
        checkOutput("str_cause_or", 32'(rst_cause_o), CFG_EN ? 32'h26 : 32'h06);
        applyStimulus(187); checkOutput("str_restart", 32'(sys_reset_o), 32'd1);
        applyStimulus(197); checkOutput("str_sys_end", 32'(sys_reset_o), 32'd1);
        applyStimulus(198); checkOutput("str_done", 32'(rst_done_o), 32'd1);

        applyStimulus(210); rst_src_i = 4'b1000;
        applyStimulus(211); rst_src_i = 4'b0000;
        checkOutput("cnt0_cause", 32'(rst_cause_o), 32'h10);
        applyStimulus(226); rst_src_i = 4'b1000;
        applyStimulus(227); rst_src_i = 4'b0000;
        checkOutput("cnt0_wins", 32'(sys_reset_o), 32'd1);
        applyStimulus(242); checkOutput("cnt0_sys_end", 32'(sys_reset_o), 32'd1);
        applyStimulus(243); checkOutput("cnt0_done", 32'(rst_done_o), 32'd1);

        applyStimulus(260); rst_src_i = 4'b0110;
        applyStimulus(261); rst_src_i = 4'b0000;
        checkOutput("multi_cause", 32'(rst_cause_o), 32'h0C);
        applyStimulus(277); checkOutput("multi_done", 32'(rst_done_o), 32'd1);

        applyStimulus(290); reset = 1'b1;
        applyStimulus(291); reset = 1'b0;
        checkOutput("rerst_cause", 32'(rst_cause_o), 32'h01);
        checkOutput("rerst_ce", 32'(ce_o), 32'd0);
        applyStimulus(307); checkOutput("rerst_done", 32'(rst_done_o), 32'd1);

        applyStimulus(320);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
